// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for the five-stage core.
// Merges stall requests, gates branch flush, tracks wrong-path fetch drain.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_stall_req,
  input  logic             id_stall_req,
  input  logic             mem_stall_req,
  input  logic             ex_b_flag_i,
  input  logic             if_busy,
  input  logic             if_resp_valid,
  output logic [5:0]       stall_state,
  output logic             flush_o,
  output logic             discard_o,
  output logic             drain_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   in_drain;

  assign in_drain = (state == DRAIN);

  // OR of nested stall masks; MEM dominates, then ID, then IF/DRAIN
  always_comb begin
    stall_state = 6'b000000;
    if (if_stall_req || in_drain)
      stall_state = stall_state | 6'b000001;
    if (id_stall_req)
      stall_state = stall_state | 6'b000011;
    if (mem_stall_req)
      stall_state = stall_state | 6'b001111;
  end

  // flush only when the branch actually leaves EX
  assign flush_o   = ex_b_flag_i & ~stall_state[3];
  assign discard_o = in_drain;
  assign drain_o   = in_drain;

  // next state: enter DRAIN on an outstanding wrong-path fetch
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (flush_o && if_busy && !if_resp_valid)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (if_resp_valid)
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= RUN;
    else
      state <= state_nxt;
  end

  // wrapping performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_state != 6'b000000)
        stall_cycles <= stall_cycles + 1'b1;
      if (flush_o)
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule
